if_fetch_unit: RTL and testbench

//   Instruction-fetch stage. Supplies the decode stage with pc/instruction pairs.

---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 104 ++++++++++
 tb/tb_if_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: fetch-stage signal bundle.
//   Byte-wide memory read port (mem_req_o/mem_addr_o/mem_gnt_i/mem_data_i),
//   EX redirect (branch_en_i/branch_addr_i), and the ID handshake
//   (inst_valid_o/pc_o/inst_o with id_ready_i).
//   master: the fetch unit. slave: memory arbiter / EX / ID side.
interface if_fetch_unit_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_data_i;
  logic        branch_en_i;
  logic [31:0] branch_addr_i;
  logic        id_ready_i;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  modport master (
    output mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o,
    input  mem_gnt_i, mem_data_i, branch_en_i, branch_addr_i, id_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o,
    output mem_gnt_i, mem_data_i, branch_en_i, branch_addr_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage.
//   Issues four byte reads (pc_o+0..3) on the shared byte memory port,
//   assembles a little-endian 32-bit instruction, and presents pc/inst to ID
//   with a valid/ready handshake. A redirect from EX reloads the pc (word
//   aligned) and abandons the fetch in progress.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (overrides rdy)
//   rdy  - global ready; low freezes all state and suppresses mem_req_o
//   bus  - if_fetch_unit_if.master (memory port, redirect, ID handshake)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  if_fetch_unit_if.master  bus
);

  typedef enum logic {
    FETCH,
    VALID
  } state_t;

  state_t      state;
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        inflight;
  logic [23:0] ibuf;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic        req;
  logic        accept;

  assign req    = ~rst & rdy & (issue_cnt < 3'd4) & ~valid_q & ~bus.branch_en_i;
  assign accept = req & bus.mem_gnt_i;

  assign bus.mem_req_o    = req;
  assign bus.mem_addr_o   = pc_q + {29'b0, issue_cnt};
  assign bus.inst_valid_o = valid_q;
  assign bus.pc_o         = pc_q;
  assign bus.inst_o       = inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      valid_q   <= 1'b0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inflight  <= 1'b0;
      ibuf      <= '0;
    end else if (rdy) begin
      inflight <= accept;
      if (bus.branch_en_i) begin
        // Redirect beats capture and transfer; any byte in flight is dropped.
        state     <= FETCH;
        pc_q      <= {bus.branch_addr_i[31:2], 2'b00};
        inst_q    <= NOP_INST;
        valid_q   <= 1'b0;
        issue_cnt <= '0;
        recv_cnt  <= '0;
        inflight  <= 1'b0;
      end else begin
        case (state)
          FETCH: begin
            if (accept) begin
              issue_cnt <= issue_cnt + 3'd1;
            end
            if (inflight) begin
              recv_cnt <= recv_cnt + 3'd1;
              case (recv_cnt)
                3'd0:    ibuf[7:0]   <= bus.mem_data_i;
                3'd1:    ibuf[15:8]  <= bus.mem_data_i;
                3'd2:    ibuf[23:16] <= bus.mem_data_i;
                default: begin
                  // Last byte goes straight into the output register.
                  inst_q  <= {bus.mem_data_i, ibuf};
                  valid_q <= 1'b1;
                  state   <= VALID;
                end
              endcase
            end
          end
          VALID: begin
            if (bus.id_ready_i) begin
              state     <= FETCH;
              pc_q      <= pc_q + 32'd4;
              inst_q    <= NOP_INST;
              valid_q   <= 1'b0;
              issue_cnt <= '0;
              recv_cnt  <= '0;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic clk;
  logic rst;
  logic rdy;
  logic [7:0] mem [0:1023];
  int checks;
  int errors;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: data appears the cycle after an accepted request, held otherwise.
  always @(posedge clk) begin
    if (bus.mem_req_o && bus.mem_gnt_i)
      bus.mem_data_i <= mem[bus.mem_addr_o[9:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task wait_valid(input int budget, output int n);
    n = 0;
    while (!bus.inst_valid_o && n < budget) begin
      step();
      n++;
    end
  endtask

  task test_reset;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid_o); end
    checks++;
    if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", bus.pc_o); end
    checks++;
    if (bus.inst_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst: got %h want 00000013", bus.inst_o); end
    checks++;
    if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.mem_req_o); end
    checks++;
    if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", bus.mem_addr_o); end
  endtask

  task test_basic;
    int n;
    logic [31:0] exp_addr;
    rst = 1'b0;
    #1;
    n = 0;
    exp_addr = 32'h0;
    while (!bus.inst_valid_o && n < 20) begin
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        checks++;
        if (bus.mem_addr_o !== exp_addr) begin errors++; $display("FAIL basic_addr: got %h want %h", bus.mem_addr_o, exp_addr); end
        exp_addr = exp_addr + 32'd1;
      end
      step();
      n++;
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", n); end
    checks++;
    if (exp_addr !== 32'd4) begin errors++; $display("FAIL basic_accepts: got %0d want 4", exp_addr); end
    checks++;
    if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h want 00000000", bus.pc_o); end
    checks++;
    if (bus.inst_o !== 32'h0010_0513) begin errors++; $display("FAIL basic_inst: got %h want 00100513", bus.inst_o); end
    bus.id_ready_i = 1'b1;
    step();
    bus.id_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL accept_valid: got %b want 0", bus.inst_valid_o); end
    checks++;
    if (bus.pc_o !== 32'h4) begin errors++; $display("FAIL accept_pc: got %h want 00000004", bus.pc_o); end
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h4)
      begin errors++; $display("FAIL accept_next_req: got req=%b addr=%h want req=1 addr=00000004", bus.mem_req_o, bus.mem_addr_o); end
  endtask

  task test_gnt_stall;
    int n;
    logic [31:0] exp_addr;
    n = 0;
    exp_addr = 32'h4;
    bus.mem_gnt_i = 1'b1;
    #1;
    while (!bus.inst_valid_o && n < 20) begin
      bus.mem_gnt_i = !(n == 1 || n == 2);
      #1;
      if (bus.mem_req_o) begin
        checks++;
        if (bus.mem_addr_o !== exp_addr) begin errors++; $display("FAIL stall_addr: cycle %0d got %h want %h", n, bus.mem_addr_o, exp_addr); end
        if (bus.mem_gnt_i) exp_addr = exp_addr + 32'd1;
      end
      step();
      n++;
    end
    bus.mem_gnt_i = 1'b1;
    checks++;
    if (n !== 7) begin errors++; $display("FAIL stall_latency: got %0d want 7", n); end
    checks++;
    if (bus.inst_o !== 32'h0010_0093) begin errors++; $display("FAIL stall_inst: got %h want 00100093", bus.inst_o); end
  endtask

  task test_id_stall;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== 32'h4 || bus.inst_o !== 32'h0010_0093 || bus.mem_req_o !== 1'b0)
        begin errors++; $display("FAIL idstall_hold: cycle %0d got v=%b pc=%h inst=%h req=%b want v=1 pc=00000004 inst=00100093 req=0",
                                 i, bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.mem_req_o); end
      step();
    end
    bus.id_ready_i = 1'b1;
    step();
    bus.id_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.pc_o !== 32'h8 || bus.inst_valid_o !== 1'b0 || bus.inst_o !== 32'h0000_0013)
      begin errors++; $display("FAIL idstall_release: got pc=%h v=%b inst=%h want pc=00000008 v=0 inst=00000013", bus.pc_o, bus.inst_valid_o, bus.inst_o); end
  endtask

  task test_redirect;
    int n;
    step();
    step();
    step();
    bus.branch_en_i   = 1'b1;
    bus.branch_addr_i = 32'h0000_0102;
    #1;
    checks++;
    if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL redirect_no_req: got %b want 0", bus.mem_req_o); end
    step();
    bus.branch_en_i = 1'b0;
    #1;
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h100 || bus.pc_o !== 32'h100)
      begin errors++; $display("FAIL redirect_target: got req=%b addr=%h pc=%h want req=1 addr=00000100 pc=00000100", bus.mem_req_o, bus.mem_addr_o, bus.pc_o); end
    wait_valid(20, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL redirect_latency: got %0d want 5", n); end
    checks++;
    if (bus.inst_o !== 32'h0000_1237 || bus.pc_o !== 32'h100)
      begin errors++; $display("FAIL redirect_inst: got inst=%h pc=%h want inst=00001237 pc=00000100", bus.inst_o, bus.pc_o); end
    bus.id_ready_i = 1'b1;
    step();
    bus.id_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.pc_o !== 32'h104) begin errors++; $display("FAIL redirect_accept_pc: got %h want 00000104", bus.pc_o); end
  endtask

  task test_rdy_freeze;
    int n;
    bus.branch_en_i   = 1'b1;
    bus.branch_addr_i = 32'h0;
    #1;
    step();
    bus.branch_en_i = 1'b0;
    n = 0;
    while (!bus.inst_valid_o && n < 20) begin
      rdy = !(n >= 2 && n <= 4);
      #1;
      if (!rdy) begin
        checks++;
        if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h2 || bus.pc_o !== 32'h0)
          begin errors++; $display("FAIL freeze_hold: cycle %0d got req=%b addr=%h pc=%h want req=0 addr=00000002 pc=00000000",
                                   n, bus.mem_req_o, bus.mem_addr_o, bus.pc_o); end
      end
      step();
      n++;
    end
    rdy = 1'b1;
    checks++;
    if (n !== 8) begin errors++; $display("FAIL freeze_latency: got %0d want 8", n); end
    checks++;
    if (bus.inst_o !== 32'h0010_0513 || bus.pc_o !== 32'h0)
      begin errors++; $display("FAIL freeze_inst: got inst=%h pc=%h want inst=00100513 pc=00000000", bus.inst_o, bus.pc_o); end
  endtask

  task test_reset_midflight;
    int n;
    rst = 1'b1;
    step();
    checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.pc_o !== 32'h0 || bus.inst_o !== 32'h13 || bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0)
      begin errors++; $display("FAIL rst_valid_state: got v=%b pc=%h inst=%h req=%b addr=%h", bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.mem_req_o, bus.mem_addr_o); end
    rst = 1'b0;
    #1;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.pc_o !== 32'h0 || bus.inst_o !== 32'h13 || bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0)
      begin errors++; $display("FAIL rst_inflight_state: got v=%b pc=%h inst=%h req=%b addr=%h", bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.mem_req_o, bus.mem_addr_o); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0)
      begin errors++; $display("FAIL rst_restart: got req=%b addr=%h want req=1 addr=00000000", bus.mem_req_o, bus.mem_addr_o); end
    wait_valid(20, n);
    checks++;
    if (n !== 5 || bus.inst_o !== 32'h0010_0513)
      begin errors++; $display("FAIL rst_refetch: got n=%0d inst=%h want n=5 inst=00100513", n, bus.inst_o); end
  endtask

  task test_redirect_on_transfer;
    int n;
    bus.id_ready_i    = 1'b1;
    bus.branch_en_i   = 1'b1;
    bus.branch_addr_i = 32'h0;
    #1;
    step();
    bus.id_ready_i  = 1'b0;
    bus.branch_en_i = 1'b0;
    #1;
    checks++;
    if (bus.pc_o !== 32'h0 || bus.inst_valid_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || bus.mem_req_o !== 1'b1)
      begin errors++; $display("FAIL redir_xfer: got pc=%h v=%b addr=%h req=%b want pc=00000000 v=0 addr=00000000 req=1",
                               bus.pc_o, bus.inst_valid_o, bus.mem_addr_o, bus.mem_req_o); end
    wait_valid(20, n);
    checks++;
    if (n !== 5 || bus.inst_o !== 32'h0010_0513)
      begin errors++; $display("FAIL redir_xfer_refetch: got n=%0d inst=%h want n=5 inst=00100513", n, bus.inst_o); end
  endtask

  task test_pc_wrap;
    int n;
    logic [31:0] exp_addr;
    bus.branch_en_i   = 1'b1;
    bus.branch_addr_i = 32'hFFFF_FFFE;
    #1;
    step();
    bus.branch_en_i = 1'b0;
    #1;
    checks++;
    if (bus.pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_align: got %h want fffffffc", bus.pc_o); end
    n = 0;
    exp_addr = 32'hFFFF_FFFC;
    while (!bus.inst_valid_o && n < 20) begin
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        checks++;
        if (bus.mem_addr_o !== exp_addr) begin errors++; $display("FAIL wrap_addr: got %h want %h", bus.mem_addr_o, exp_addr); end
        exp_addr = exp_addr + 32'd1;
      end
      step();
      n++;
    end
    checks++;
    if (n !== 5 || bus.inst_o !== 32'h0000_006F)
      begin errors++; $display("FAIL wrap_inst: got n=%0d inst=%h want n=5 inst=0000006f", n, bus.inst_o); end
    bus.id_ready_i = 1'b1;
    step();
    bus.id_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.pc_o !== 32'h0 || bus.mem_addr_o !== 32'h0 || bus.mem_req_o !== 1'b1)
      begin errors++; $display("FAIL wrap_pc: got pc=%h addr=%h req=%b want pc=00000000 addr=00000000 req=1", bus.pc_o, bus.mem_addr_o, bus.mem_req_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h10; mem[3]     = 8'h00;
    mem[4]     = 8'h93; mem[5]     = 8'h00; mem[6]     = 8'h10; mem[7]     = 8'h00;
    mem[10'h100] = 8'h37; mem[10'h101] = 8'h12; mem[10'h102] = 8'h00; mem[10'h103] = 8'h00;
    mem[10'h3FC] = 8'h6F; mem[10'h3FD] = 8'h00; mem[10'h3FE] = 8'h00; mem[10'h3FF] = 8'h00;
    rst               = 1'b1;
    rdy               = 1'b1;
    bus.mem_gnt_i     = 1'b1;
    bus.mem_data_i    = 8'h00;
    bus.branch_en_i   = 1'b0;
    bus.branch_addr_i = 32'h0;
    bus.id_ready_i    = 1'b0;

    test_reset();
    test_basic();
    test_gnt_stall();
    test_id_stall();
    test_redirect();
    test_rdy_freeze();
    test_reset_midflight();
    test_redirect_on_transfer();
    test_pc_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
